sram_seq_ctrl: RTL and testbench

Access sequencer and two-port arbiter for the 8-word register-file array. The array is addressed through the 3-to-8 wordline decoder with a valid gate.
- Accepts read/write requests from two requesters and grants them round-robin.
- Drives the array's address, wordline-valid, precharge, write-enable and sense-enable strobes in a fixed phase order.
- Returns read data or a write acknowledge to the granted requester.

---
 rtl/sram_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sram_seq_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sram_seq_ctrl.sv
// rtl/sram_seq_ctrl.sv - round-robin two-port access sequencer for the 8-word register-file array
// Optional perf counters: define SRAM_SEQ_CTRL_PERF_EN.
module sram_seq_ctrl #(
  parameter int DATA_W    = 8,
  parameter int WL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [2:0]        req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [2:0]        req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [2:0]        arr_addr,
  output logic              arr_valid,
  output logic              arr_precharge,
  output logic              arr_we,
  output logic [DATA_W-1:0] arr_wdata,
  output logic              arr_sense_en,
  input  logic [DATA_W-1:0] arr_rdata
`ifdef SRAM_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_grant0,
  output logic [15:0]       perf_grant1,
  output logic [15:0]       perf_conflict
`endif
);

  if (WL_CYCLES < 1 || WL_CYCLES > 4) begin : g_bad_wl_cycles
    $error("sram_seq_ctrl: WL_CYCLES must be in 1..4");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WL, S_SENSE, S_RESP} state_t;

  localparam logic [1:0] WL_LAST = 2'(WL_CYCLES - 1);

  state_t            r_state;
  logic              r_rr;
  logic              r_id;
  logic              r_we;
  logic [2:0]        r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_cnt;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic              r_rsp_we;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_arr_valid;
  logic              r_arr_precharge;
  logic              r_arr_we;
  logic              r_arr_sense_en;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_accept;

  // r_rr = 0 prefers requester 0 when both are valid
  assign w_idle   = (r_state == S_IDLE);
  assign w_grant1 = req1_valid & (~req0_valid | r_rr);
  assign w_grant0 = req0_valid & ~w_grant1;
  assign w_accept = w_idle & (req0_valid | req1_valid);

  assign req0_ready    = rst_n & w_idle & w_grant0;
  assign req1_ready    = rst_n & w_idle & w_grant1;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_rsp_id;
  assign rsp_we        = r_rsp_we;
  assign rsp_rdata     = r_rsp_rdata;
  assign arr_addr      = r_addr;
  assign arr_wdata     = r_wdata;
  assign arr_valid     = r_arr_valid;
  assign arr_precharge = r_arr_precharge;
  assign arr_we        = r_arr_we;
  assign arr_sense_en  = r_arr_sense_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_rr            <= 1'b0;
      r_id            <= 1'b0;
      r_we            <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_cnt           <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_id        <= 1'b0;
      r_rsp_we        <= 1'b0;
      r_rsp_rdata     <= '0;
      r_arr_valid     <= 1'b0;
      r_arr_precharge <= 1'b0;
      r_arr_we        <= 1'b0;
      r_arr_sense_en  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (w_accept) begin
            r_state         <= S_PRE;
            r_id            <= w_grant1;
            r_we            <= w_grant1 ? req1_we    : req0_we;
            r_addr          <= w_grant1 ? req1_addr  : req0_addr;
            r_wdata         <= w_grant1 ? req1_wdata : req0_wdata;
            r_rr            <= ~w_grant1;
            r_arr_precharge <= 1'b1;
          end
        end
        S_PRE: begin
          r_state         <= S_WL;
          r_arr_precharge <= 1'b0;
          r_arr_valid     <= 1'b1;
          r_arr_we        <= r_we;
          r_cnt           <= '0;
        end
        S_WL: begin
          if (r_cnt == WL_LAST) begin
            r_arr_valid <= 1'b0;
            r_arr_we    <= 1'b0;
            if (r_we) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= r_id;
              r_rsp_we    <= 1'b1;
            end else begin
              r_state        <= S_SENSE;
              r_arr_sense_en <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_SENSE: begin
          r_state        <= S_RESP;
          r_arr_sense_en <= 1'b0;
          r_rsp_rdata    <= arr_rdata;
          r_rsp_valid    <= 1'b1;
          r_rsp_id       <= r_id;
          r_rsp_we       <= 1'b0;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
        default: begin
          r_state         <= S_IDLE;
          r_rsp_valid     <= 1'b0;
          r_arr_valid     <= 1'b0;
          r_arr_precharge <= 1'b0;
          r_arr_we        <= 1'b0;
          r_arr_sense_en  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SRAM_SEQ_CTRL_PERF_EN
  logic [15:0] r_perf_grant0;
  logic [15:0] r_perf_grant1;
  logic [15:0] r_perf_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_grant0   <= '0;
      r_perf_grant1   <= '0;
      r_perf_conflict <= '0;
    end else if (w_accept) begin
      if (w_grant0 && r_perf_grant0 != 16'hFFFF) r_perf_grant0 <= r_perf_grant0 + 16'd1;
      if (w_grant1 && r_perf_grant1 != 16'hFFFF) r_perf_grant1 <= r_perf_grant1 + 16'd1;
      if (req0_valid && req1_valid && r_perf_conflict != 16'hFFFF)
        r_perf_conflict <= r_perf_conflict + 16'd1;
    end
  end

  assign perf_grant0   = r_perf_grant0;
  assign perf_grant1   = r_perf_grant1;
  assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// tb/tb_sram_seq_ctrl.sv - directed self-checking bench for sram_seq_ctrl
// Two instances: WL_CYCLES=1 (main) and WL_CYCLES=3 (wordline hold length).
module tb_sram_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [2:0] req0_addr = 0, req1_addr = 0;
  logic [7:0] req0_wdata = 0, req1_wdata = 0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_we;
  logic [7:0] rsp_rdata, arr_wdata, arr_rdata;
  logic [2:0] arr_addr;
  logic       arr_valid, arr_precharge, arr_we, arr_sense_en;

  logic       b_req0_valid = 0, b_req0_we = 0, b_req1_valid = 0, b_req1_we = 0;
  logic [2:0] b_req0_addr = 0, b_req1_addr = 0;
  logic [7:0] b_req0_wdata = 0, b_req1_wdata = 0;
  logic       b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_rsp_we;
  logic [7:0] b_rsp_rdata, b_arr_wdata, b_arr_rdata;
  logic [2:0] b_arr_addr;
  logic       b_arr_valid, b_arr_precharge, b_arr_we, b_arr_sense_en;

`ifdef SRAM_SEQ_CTRL_PERF_EN
  logic [15:0] pg0, pg1, pc, b_pg0, b_pg1, b_pc;
`endif

  sram_seq_ctrl #(.DATA_W(8), .WL_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .arr_addr(arr_addr), .arr_valid(arr_valid), .arr_precharge(arr_precharge),
    .arr_we(arr_we), .arr_wdata(arr_wdata), .arr_sense_en(arr_sense_en),
    .arr_rdata(arr_rdata)
`ifdef SRAM_SEQ_CTRL_PERF_EN
    , .perf_grant0(pg0), .perf_grant1(pg1), .perf_conflict(pc)
`endif
  );

  sram_seq_ctrl #(.DATA_W(8), .WL_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_we(b_req0_we),
    .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_we(b_req1_we),
    .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_we(b_rsp_we), .rsp_rdata(b_rsp_rdata),
    .arr_addr(b_arr_addr), .arr_valid(b_arr_valid), .arr_precharge(b_arr_precharge),
    .arr_we(b_arr_we), .arr_wdata(b_arr_wdata), .arr_sense_en(b_arr_sense_en),
    .arr_rdata(b_arr_rdata)
`ifdef SRAM_SEQ_CTRL_PERF_EN
    , .perf_grant0(b_pg0), .perf_grant1(b_pg1), .perf_conflict(b_pc)
`endif
  );

  // 8-word array model for the main instance; the second one returns a fixed word
  logic [7:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
  always @(posedge clk) if (arr_valid && arr_we) mem[arr_addr] <= arr_wdata;
  assign arr_rdata   = arr_sense_en ? mem[arr_addr] : 8'h00;
  assign b_arr_rdata = b_arr_sense_en ? 8'h3C : 8'h00;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, both_hi = 0, overlap = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (req0_ready && req1_ready) both_hi <= both_hi + 1;
    if ((arr_valid && arr_precharge) || (b_arr_valid && b_arr_precharge)) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] all_out();
    return {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_we, rsp_rdata, arr_addr,
            arr_valid, arr_precharge, arr_we, arr_wdata, arr_sense_en};
  endfunction

  initial begin
    int last_acc, wait_n, seen_rsp;
    logic exp_id;

    // reset, then 20 idle cycles with no strobes
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", 32'(all_out()), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("idle_outputs", 32'(all_out()), 0);
    end

    // req0 write addr 5 = A5
    req0_valid = 1; req0_we = 1; req0_addr = 3'd5; req0_wdata = 8'hA5; #1;
    check("wr_ready", 32'({req0_ready, req1_ready}), 2'b10);
    @(negedge clk); req0_valid = 0; #1;
    check("wr_pre", 32'({arr_precharge, arr_valid, arr_we}), 3'b100);
    @(negedge clk); #1;
    check("wr_wl", 32'({arr_precharge, arr_valid, arr_we}), 3'b011);
    check("wr_addr", 32'(arr_addr), 5);
    check("wr_wdata", 32'(arr_wdata), 32'hA5);
    @(negedge clk); #1;
    check("wr_rsp", 32'({rsp_valid, rsp_id, rsp_we, arr_valid}), 4'b1010);
    @(negedge clk); #1;
    check("wr_rsp_end", 32'(rsp_valid), 0);

    // req1 read back addr 5
    req1_valid = 1; req1_we = 0; req1_addr = 3'd5; #1;
    check("rd_ready", 32'({req0_ready, req1_ready}), 2'b01);
    @(negedge clk); req1_valid = 0; #1;
    check("rd_pre", 32'({arr_precharge, arr_valid, arr_sense_en}), 3'b100);
    @(negedge clk); #1;
    check("rd_wl", 32'({arr_valid, arr_we, arr_sense_en}), 3'b100);
    @(negedge clk); #1;
    check("rd_sense", 32'({arr_valid, arr_sense_en, rsp_valid}), 3'b010);
    check("rd_addr", 32'(arr_addr), 5);
    @(negedge clk); #1;
    check("rd_rsp", 32'({rsp_valid, rsp_id, rsp_we}), 3'b110);
    check("rd_rdata", 32'(rsp_rdata), 32'hA5);
    @(negedge clk); #1;
    check("rd_rsp_end", 32'(rsp_valid), 0);

    // continuous contention, 6 reads
    req0_valid = 1; req0_we = 0; req0_addr = 3'd1;
    req1_valid = 1; req1_we = 0; req1_addr = 3'd2;
    last_acc = 0;
    for (int k = 0; k < 6; k++) begin
      wait_n = 0;
      #1;
      while (!(req0_ready || req1_ready) && wait_n < 20) begin
        @(negedge clk); #1; wait_n++;
      end
      check("arb_wait", 32'(wait_n < 20), 1);
      exp_id = k[0];
      check("arb_order", 32'({req0_ready, req1_ready}), exp_id ? 2'b01 : 2'b10);
      if (k > 0) check("arb_spacing", 32'(cyc - last_acc), 5);
      last_acc = cyc;
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (6) @(negedge clk);
    check("arb_never_both", 32'(both_hi), 0);

    // WL_CYCLES=3 read addr 7
    b_req0_valid = 1; b_req0_we = 0; b_req0_addr = 3'd7; #1;
    check("wl3_ready", 32'(b_req0_ready), 1);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk); b_req0_valid = 0; #1;
      check("wl3_phase", 32'({b_arr_precharge, b_arr_valid, b_arr_sense_en, b_rsp_valid}),
            32'({i == 1, (i >= 2 && i <= 4), i == 5, i == 6}));
      if (i == 3) check("wl3_addr", 32'(b_arr_addr), 7);
      if (i == 6) check("wl3_rdata", 32'(b_rsp_rdata), 32'h3C);
    end
    check("no_overlap", 32'(overlap), 0);

    // reset during WL of a req0 write (rr pointer then points at req1)
    req0_valid = 1; req0_we = 1; req0_addr = 3'd3; req0_wdata = 8'h5A; #1;
    check("rst_wr_ready", 32'(req0_ready), 1);
    @(negedge clk); req0_valid = 0;
    @(negedge clk); #1;
    check("rst_wr_wl", 32'({arr_valid, arr_we}), 2'b11);
    #2 rst_n = 1'b0; #1;
    check("rst_async_drop", 32'({arr_valid, arr_we, arr_precharge, rsp_valid}), 0);
    seen_rsp = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) seen_rsp++;
    end
    check("rst_no_rsp", 32'(seen_rsp), 0);
    check("rst_no_write", 32'(mem[3]), 0);
    req0_valid = 1; req0_we = 0; req1_valid = 1; req1_we = 0; #1;
    check("rst_rr_req0", 32'({req0_ready, req1_ready}), 2'b10);
    @(negedge clk); req0_valid = 0; req1_valid = 0;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
